// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters with a hold-time limit.
// All outputs are flops; the one-hot grant is registered alongside its index.
module rr_arb8 #(
  parameter int MAX_HOLD = 16,
  localparam int CW = $clog2(MAX_HOLD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q;
  logic [2:0]    ptr_q;
  logic [2:0]    idx_q;
  logic          vld_q;
  logic [7:0]    gnt_q;
  logic [CW-1:0] hold_q;

  logic [7:0] own;
  logic [7:0] others;
  logic [2:0] sel_idle;
  logic [2:0] sel_rel;
  logic [2:0] sel_pre;
  logic       timeout;

  // First set bit of v, scanning upward from (p+1) and wrapping 7->0.
  function automatic logic [2:0] search(input logic [7:0] v, input logic [2:0] p);
    logic [2:0] j;
    logic       found;
    search = p;
    found  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      j = p + 3'(k);
      if (!found && v[j]) begin
        search = j;
        found  = 1'b1;
      end
    end
  endfunction

  assign own      = 8'h01 << idx_q;
  assign others   = req & ~own;
  assign sel_idle = search(req, ptr_q);
  assign sel_rel  = search(req, idx_q);
  assign sel_pre  = search(others, idx_q);
  assign timeout  = (hold_q == CW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd7;
      idx_q   <= 3'd0;
      vld_q   <= 1'b0;
      gnt_q   <= 8'h00;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && |req) begin
            state_q <= GRANT;
            idx_q   <= sel_idle;
            vld_q   <= 1'b1;
            gnt_q   <= 8'h01 << sel_idle;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (!en) begin
            state_q <= IDLE;
            ptr_q   <= idx_q;
            vld_q   <= 1'b0;
            gnt_q   <= 8'h00;
          end else if (!req[idx_q]) begin
            ptr_q <= idx_q;
            if (|req) begin
              // Hand over on the same edge so there is no idle bubble.
              idx_q  <= sel_rel;
              gnt_q  <= 8'h01 << sel_rel;
              hold_q <= '0;
            end else begin
              state_q <= IDLE;
              vld_q   <= 1'b0;
              gnt_q   <= 8'h00;
            end
          end else if (timeout && |others) begin
            ptr_q  <= idx_q;
            idx_q  <= sel_pre;
            gnt_q  <= 8'h01 << sel_pre;
            hold_q <= '0;
          end else if (!timeout) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;

endmodule
